pcie_dplbuf_arb: RTL and testbench
==================================

PCIE_DPLBUF_ARB -- requirements
Module: pcie_dplbuf_arb

Interface
REQ-001 The parameter LINKS SHALL default to 12 and set the number of requesting links.
REQ-002 The parameter BLK_BEATS SHALL default to 128 and set the 256-bit beats per 4KB block.
REQ-003 The parameter TIMEOUT SHALL default to 1024 and set the idle-cycle limit while a block is in progress.
REQ-004 iCLK  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-005 iRST  in  1  reset, asynchronous, active-high.
REQ-006 iDPLBUF_REQ  in  LINKS  per-link block request, level, held until granted.
REQ-007 oDPLBUF_GNT  out  LINKS  per-link grant, one-hot, single-cycle pulse.
REQ-008 iDPLBUF_DATA  in  256  OR-combined beat data from all links.
REQ-009 iDPLBUF_DATA_V  in  LINKS  per-link beat valid.
REQ-010 iBUF_AFULL  in  1  downstream buffer cannot accept another full block.
REQ-011 oWR_EN  out  1  write strobe for one beat.
REQ-012 oWR_DATA  out  256  beat data.
REQ-013 oWR_LINK  out  4  link index of the beat.
REQ-014 oWR_BEAT  out  7  beat index within block, 0..BLK_BEATS-1.
REQ-015 oWR_EOB  out  1  asserted with oWR_EN on the last beat of a block.
REQ-016 iERR_CLR  in  1  single-cycle clear of the sticky error flags.
REQ-017 oERR_UNEXP  out  1  sticky: data_v seen from a non-owner link or outside XFER.
REQ-018 oERR_TMO  out  1  sticky: block aborted by timeout.

Function
REQ-019 The FSM SHALL have states IDLE, GNT, XFER and DONE.
REQ-020 IDLE->GNT when any iDPLBUF_REQ is set and iBUF_AFULL is low; otherwise the FSM SHALL stay in IDLE.
REQ-021 In IDLE the owner SHALL be the first requesting link at or after rr_ptr in ascending order, wrapping LINKS-1 to 0.
REQ-022 In GNT oDPLBUF_GNT[owner] SHALL be high for exactly one cycle, then GNT->XFER.
REQ-023 In XFER each cycle with iDPLBUF_DATA_V[owner] high SHALL produce, one cycle later, oWR_EN=1, oWR_DATA=iDPLBUF_DATA, oWR_LINK=owner, oWR_BEAT=beat count.
REQ-024 The beat counter SHALL be 7 bits, reset to 0 on entry to XFER, and increment per owner beat.
REQ-025 On owner beat BLK_BEATS-1, oWR_EOB SHALL be high with that beat and XFER->DONE.
REQ-026 DONE SHALL last one cycle, set rr_ptr to owner+1 (owner LINKS-1 wraps to 0), then DONE->IDLE.
REQ-027 iDPLBUF_DATA_V bits of non-owner links, or any bit outside XFER, SHALL set oERR_UNEXP and SHALL NOT write.
REQ-028 iBUF_AFULL SHALL be sampled only in IDLE; a block in XFER SHALL always complete.
REQ-029 iERR_CLR SHALL clear both sticky flags; a simultaneous set condition SHALL take priority over clear.
REQ-030 At most one oDPLBUF_GNT bit SHALL be high in any cycle, and grants SHALL be at least BLK_BEATS+3 cycles apart.

Reset
REQ-031 While iRST is high: FSM=IDLE, rr_ptr=0, beat count=0, oDPLBUF_GNT=0, oWR_EN=0, oWR_EOB=0, oWR_DATA=0, oWR_LINK=0, oWR_BEAT=0, oERR_UNEXP=0, oERR_TMO=0.
REQ-032 Reset asserted mid-block SHALL abandon the block with no further writes; after release, arbitration SHALL restart from link 0.

Configuration
REQ-033 With macro PCIE_DPLBUF_ARB_TIMEOUT_EN defined, an idle counter SHALL count XFER cycles without an owner beat and SHALL clear on each owner beat.
REQ-034 With PCIE_DPLBUF_ARB_TIMEOUT_EN defined, the count reaching TIMEOUT SHALL set oERR_TMO and force XFER->DONE with no oWR_EOB.
REQ-035 Without PCIE_DPLBUF_ARB_TIMEOUT_EN, the counter SHALL be absent, XFER SHALL wait indefinitely, and oERR_TMO SHALL be tied to 0.

Verification
REQ-036 Link 3 req only, 128 consecutive beats -> GNT[3] pulses once; 128 writes with oWR_LINK=3, oWR_BEAT 0..127, oWR_EOB on beat 127.
REQ-037 Links 0, 5 and 11 req together from reset -> grant order 0, 5, 11, then 0 again if still requesting.
REQ-038 Owner 2 in XFER, data_v[7] pulsed -> oERR_UNEXP=1, no write for link 7; iERR_CLR -> 0.
REQ-039 iBUF_AFULL=1 with link 1 requesting -> no grant; AFULL=0 -> GNT[1] next cycle; AFULL raised mid-block -> block still completes all 128 beats.
REQ-040 PCIE_DPLBUF_ARB_TIMEOUT_EN, TIMEOUT=16, owner sends 10 beats then stops -> oERR_TMO after 16 idle cycles, FSM returns to IDLE, next link granted.
REQ-041 iRST asserted at beat 60 -> all outputs 0 immediately; after release, a new block with link 0 requesting starts at oWR_BEAT=0.

Source files
------------

// File: rtl/pcie_dplbuf_arb.sv
`default_nettype none
// ==========================================================================
// pcie_dplbuf_arb : round-robin arbiter granting whole 4KB blocks to links.
// Option macro PCIE_DPLBUF_ARB_TIMEOUT_EN adds the XFER idle timeout. Rev 1.0
// ==========================================================================
module pcie_dplbuf_arb #(
  parameter int LINKS     = 12,
  parameter int BLK_BEATS = 128,
  parameter int TIMEOUT   = 1024
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [LINKS-1:0] iDPLBUF_REQ,
  output logic [LINKS-1:0] oDPLBUF_GNT,
  input  logic [255:0]     iDPLBUF_DATA,
  input  logic [LINKS-1:0] iDPLBUF_DATA_V,
  input  logic             iBUF_AFULL,
  output logic             oWR_EN,
  output logic [255:0]     oWR_DATA,
  output logic [3:0]       oWR_LINK,
  output logic [6:0]       oWR_BEAT,
  output logic             oWR_EOB,
  input  logic             iERR_CLR,
  output logic             oERR_UNEXP,
  output logic             oERR_TMO
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [6:0] LAST_BEAT = 7'(BLK_BEATS - 1);
  localparam logic [3:0] LAST_LINK = 4'(LINKS - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       owner_q, owner_d;
  logic [3:0]       rr_q, rr_d;
  logic [6:0]       beat_q, beat_d;
  logic             wr_en_q, wr_en_d;
  logic [255:0]     wr_data_q, wr_data_d;
  logic [3:0]       wr_link_q, wr_link_d;
  logic [6:0]       wr_beat_q, wr_beat_d;
  logic             wr_eob_q, wr_eob_d;
  logic             unexp_q, unexp_d;

  logic [LINKS-1:0] w_own_oh;
  logic             w_own_beat;
  logic             w_unexp;
  logic [3:0]       w_pick;
  logic             w_pick_vld;

  assign w_own_oh   = LINKS'(1) << owner_q;
  assign w_own_beat = (state_q == ST_XFER) && |(iDPLBUF_DATA_V & w_own_oh);
  // Any valid outside XFER is a stray; inside XFER only the owner may talk.
  assign w_unexp    = (state_q == ST_XFER) ? |(iDPLBUF_DATA_V & ~w_own_oh)
                                           : |iDPLBUF_DATA_V;

  always_comb begin
    w_pick     = rr_q;
    w_pick_vld = 1'b0;
    for (int i = 0; i < LINKS; i++) begin
      if (!w_pick_vld && iDPLBUF_REQ[(int'(rr_q) + i) % LINKS]) begin
        w_pick_vld = 1'b1;
        w_pick     = 4'((int'(rr_q) + i) % LINKS);
      end
    end
  end

`ifdef PCIE_DPLBUF_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          tmo_q, tmo_d;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    wr_en_d   = 1'b0;
    wr_eob_d  = 1'b0;
    wr_data_d = wr_data_q;
    wr_link_d = wr_link_q;
    wr_beat_d = wr_beat_q;
    unexp_d   = w_unexp ? 1'b1 : (iERR_CLR ? 1'b0 : unexp_q);
`ifdef PCIE_DPLBUF_ARB_TIMEOUT_EN
    idle_d    = idle_q;
    tmo_d     = iERR_CLR ? 1'b0 : tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (w_pick_vld && !iBUF_AFULL) begin
          owner_d = w_pick;
          state_d = ST_GNT;
        end
      end
      ST_GNT: begin
        beat_d  = '0;
        state_d = ST_XFER;
`ifdef PCIE_DPLBUF_ARB_TIMEOUT_EN
        idle_d  = '0;
`endif
      end
      ST_XFER: begin
        if (w_own_beat) begin
          wr_en_d   = 1'b1;
          wr_data_d = iDPLBUF_DATA;
          wr_link_d = owner_q;
          wr_beat_d = beat_q;
          beat_d    = beat_q + 7'd1;
`ifdef PCIE_DPLBUF_ARB_TIMEOUT_EN
          idle_d    = '0;
`endif
          if (beat_q == LAST_BEAT) begin
            wr_eob_d = 1'b1;
            state_d  = ST_DONE;
          end
        end
`ifdef PCIE_DPLBUF_ARB_TIMEOUT_EN
        else if (idle_q == TW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          idle_d  = '0;
          state_d = ST_DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        rr_d    = (owner_q == LAST_LINK) ? 4'd0 : owner_q + 4'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      beat_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_link_q <= '0;
      wr_beat_q <= '0;
      wr_eob_q  <= 1'b0;
      unexp_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      beat_q    <= beat_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_link_q <= wr_link_d;
      wr_beat_q <= wr_beat_d;
      wr_eob_q  <= wr_eob_d;
      unexp_q   <= unexp_d;
    end
  end

`ifdef PCIE_DPLBUF_ARB_TIMEOUT_EN
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
    end
  end
  assign oERR_TMO = tmo_q;
`else
  assign oERR_TMO = 1'b0;
`endif

  assign oDPLBUF_GNT = (state_q == ST_GNT) ? w_own_oh : '0;
  assign oWR_EN      = wr_en_q;
  assign oWR_DATA    = wr_data_q;
  assign oWR_LINK    = wr_link_q;
  assign oWR_BEAT    = wr_beat_q;
  assign oWR_EOB     = wr_eob_q;
  assign oERR_UNEXP  = unexp_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_dplbuf_arb.sv
`default_nettype none
// ==========================================================================
// tb_pcie_dplbuf_arb : directed self-checking bench for pcie_dplbuf_arb.
// Exercises PCIE_DPLBUF_ARB_TIMEOUT_EN when defined. Rev 1.0
// ==========================================================================
module tb_pcie_dplbuf_arb;
  localparam int LINKS = 12;
  localparam int BB    = 128;

  logic             iCLK = 1'b0;
  logic             iRST = 1'b1;
  logic [LINKS-1:0] iDPLBUF_REQ = '0;
  logic [LINKS-1:0] oDPLBUF_GNT;
  logic [255:0]     iDPLBUF_DATA = '0;
  logic [LINKS-1:0] iDPLBUF_DATA_V = '0;
  logic             iBUF_AFULL = 1'b0;
  logic             oWR_EN;
  logic [255:0]     oWR_DATA;
  logic [3:0]       oWR_LINK;
  logic [6:0]       oWR_BEAT;
  logic             oWR_EOB;
  logic             iERR_CLR = 1'b0;
  logic             oERR_UNEXP;
  logic             oERR_TMO;

  int vec = 0;
  int mis = 0;
  int cyc = 0;
  int last_gnt = -1000;

  pcie_dplbuf_arb #(.LINKS(LINKS), .BLK_BEATS(BB), .TIMEOUT(16)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iDPLBUF_REQ(iDPLBUF_REQ), .oDPLBUF_GNT(oDPLBUF_GNT),
    .iDPLBUF_DATA(iDPLBUF_DATA), .iDPLBUF_DATA_V(iDPLBUF_DATA_V),
    .iBUF_AFULL(iBUF_AFULL),
    .oWR_EN(oWR_EN), .oWR_DATA(oWR_DATA), .oWR_LINK(oWR_LINK),
    .oWR_BEAT(oWR_BEAT), .oWR_EOB(oWR_EOB),
    .iERR_CLR(iERR_CLR), .oERR_UNEXP(oERR_UNEXP), .oERR_TMO(oERR_TMO)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
    cyc++;
  endtask

  function automatic logic [255:0] pat(input int link, input int i);
    logic [255:0] v;
    for (int k = 0; k < 8; k++)
      v[k*32 +: 32] = 32'hC0DE_0000 ^ 32'(k << 20) ^ 32'(link << 8) ^ 32'(i);
    return v;
  endfunction

  task automatic wait_grant(input int link, input bit chk_gap);
    int n = 0;
    while (oDPLBUF_GNT == '0 && n < 400) begin
      step();
      n++;
    end
    chk("grant", 256'(oDPLBUF_GNT), 256'(LINKS'(1) << link));
    if (chk_gap) chk("grant_gap", 256'(cyc - last_gnt >= BB + 3), 256'(1));
    last_gnt = cyc;
    iDPLBUF_REQ[link] = 1'b0;
  endtask

  task automatic enter_xfer();
    step();
    chk("grant_single_pulse", 256'(oDPLBUF_GNT), 256'(0));
  endtask

  task automatic beats(input int link, input int from, input int to);
    for (int i = from; i < to; i++) begin
      iDPLBUF_DATA   = pat(link, i);
      iDPLBUF_DATA_V = LINKS'(1) << link;
      step();
      chk("wr_en",   256'(oWR_EN),   256'(1));
      chk("wr_link", 256'(oWR_LINK), 256'(link));
      chk("wr_beat", 256'(oWR_BEAT), 256'(i));
      chk("wr_eob",  256'(oWR_EOB),  256'(i == BB - 1));
      chk("wr_data", oWR_DATA,       pat(link, i));
    end
    iDPLBUF_DATA_V = '0;
    iDPLBUF_DATA   = '0;
  endtask

  task automatic finish_block();
    step();
    chk("done_wr_en",  256'(oWR_EN),  256'(0));
    chk("done_wr_eob", 256'(oWR_EOB), 256'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   256'(oDPLBUF_GNT), 256'(0));
    chk({tag, "_wr_en"}, 256'(oWR_EN),      256'(0));
    chk({tag, "_eob"},   256'(oWR_EOB),     256'(0));
    chk({tag, "_data"},  oWR_DATA,          256'(0));
    chk({tag, "_link"},  256'(oWR_LINK),    256'(0));
    chk({tag, "_beat"},  256'(oWR_BEAT),    256'(0));
    chk({tag, "_unexp"}, 256'(oERR_UNEXP),  256'(0));
    chk({tag, "_tmo"},   256'(oERR_TMO),    256'(0));
  endtask

  initial begin
    // Reset values
    step();
    step();
    chk_all_zero("reset");
    iRST = 1'b0;

    // Single requester link 3, full block
    iDPLBUF_REQ[3] = 1'b1;
    wait_grant(3, 1'b1);
    enter_xfer();
    beats(3, 0, BB);
    finish_block();
    chk("blk3_unexp", 256'(oERR_UNEXP), 256'(0));

    // Owner 2, stray valid from link 7; set beats clear
    iDPLBUF_REQ[2] = 1'b1;
    wait_grant(2, 1'b1);
    enter_xfer();
    beats(2, 0, 5);
    iDPLBUF_DATA_V = LINKS'(1) << 7;
    iDPLBUF_DATA   = pat(7, 0);
    step();
    chk("stray_no_write", 256'(oWR_EN),     256'(0));
    chk("stray_unexp",    256'(oERR_UNEXP), 256'(1));
    iERR_CLR = 1'b1;
    step();
    chk("set_beats_clear", 256'(oERR_UNEXP), 256'(1));
    iDPLBUF_DATA_V = '0;
    step();
    iERR_CLR = 1'b0;
    chk("clear_unexp",   256'(oERR_UNEXP), 256'(0));
    chk("clear_wr_en",   256'(oWR_EN),     256'(0));
    beats(2, 5, BB);
    finish_block();

    // Almost-full blocks arbitration but not an active block
    iBUF_AFULL     = 1'b1;
    iDPLBUF_REQ[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("afull_no_grant", 256'(oDPLBUF_GNT), 256'(0));
    end
    iBUF_AFULL = 1'b0;
    step();
    chk("afull_release_grant", 256'(oDPLBUF_GNT), 256'(LINKS'(1) << 1));
    iDPLBUF_REQ[1] = 1'b0;
    last_gnt = cyc;
    enter_xfer();
    beats(1, 0, 50);
    iBUF_AFULL = 1'b1;
    beats(1, 50, BB);
    finish_block();
    iDPLBUF_REQ[4] = 1'b1;
    step();
    step();
    chk("afull_hold_off", 256'(oDPLBUF_GNT), 256'(0));
    iBUF_AFULL = 1'b0;

    // Reset in the middle of a block
    wait_grant(4, 1'b1);
    enter_xfer();
    beats(4, 0, 61);
    #1;
    iRST = 1'b1;
    #1;
    chk_all_zero("midrst");
    step();
    chk("midrst_hold_wr_en", 256'(oWR_EN), 256'(0));
    #2;
    iRST = 1'b0;
    last_gnt = -1000;

    // Links 0, 5, 11 together: order 0, 5, 11, then 0 again
    iDPLBUF_REQ = '0;
    iDPLBUF_REQ[0] = 1'b1;
    iDPLBUF_REQ[5] = 1'b1;
    iDPLBUF_REQ[11] = 1'b1;
    wait_grant(0, 1'b1);
    enter_xfer();
    beats(0, 0, BB);
    finish_block();
    iDPLBUF_REQ[0] = 1'b1;
    wait_grant(5, 1'b1);
    enter_xfer();
    beats(5, 0, BB);
    finish_block();
    wait_grant(11, 1'b1);
    enter_xfer();
    beats(11, 0, BB);
    finish_block();
    wait_grant(0, 1'b1);
    enter_xfer();

`ifdef PCIE_DPLBUF_ARB_TIMEOUT_EN
    beats(0, 0, 10);
    for (int k = 1; k < 16; k++) begin
      step();
      chk("tmo_not_yet", 256'(oERR_TMO), 256'(0));
    end
    step();
    chk("tmo_set",   256'(oERR_TMO), 256'(1));
    chk("tmo_no_eob", 256'(oWR_EOB), 256'(0));
    chk("tmo_no_wr", 256'(oWR_EN),   256'(0));
    iDPLBUF_REQ[5] = 1'b1;
    wait_grant(5, 1'b0);
    iERR_CLR = 1'b1;
    step();
    iERR_CLR = 1'b0;
    chk("tmo_clear", 256'(oERR_TMO), 256'(0));
`else
    beats(0, 0, BB);
    finish_block();
    chk("tmo_tied_low", 256'(oERR_TMO), 256'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
`default_nettype wire
